fifo_rd_stream_checker: RTL and testbench

Read-side consumer for the 1:2 asymmetric-width R0_FIFO test path. It runs in the read clock domain and drives the FIFO read enable. It waits for the programmable-full trigger, then drains the FIFO continuously and checks every 32-bit read word against the packed incrementing 16-bit write pattern. Results go to a sticky error flag, counters and a capture register for LEDs and debug probes; it stands in for the golden-FIFO comparison path.

---
 rtl/fifo_rd_stream_checker.sv | 123 ++++++++++++
 tb/tb_fifo_rd_stream_checker.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream_checker.sv
// Read-side stream checker for the 1:2 asymmetric R0_FIFO path.
// Drains after prog-full and checks packed incrementing half-words.
module fifo_rd_stream_checker #(
  parameter int DATA_WIDTH     = 32,
  parameter int ERR_CNT_WIDTH  = 16,
  parameter int WORD_CNT_WIDTH = 32
) (
  input  logic                      rd_clk,
  input  logic                      sys_rst_n,
  input  logic                      enable_i,
  input  logic                      rst_busy_i,
  input  logic                      prog_full_i,
  input  logic                      empty_i,
  input  logic [DATA_WIDTH-1:0]     rdata_i,
  input  logic                      rd_valid_i,
  output logic                      rd_en_o,
  output logic                      seeded_o,
  output logic                      err_o,
  output logic [ERR_CNT_WIDTH-1:0]  err_cnt_o,
  output logic [WORD_CNT_WIDTH-1:0] word_cnt_o,
  output logic [DATA_WIDTH-1:0]     first_err_data_o,
  output logic [1:0]                state_o
);

  localparam int HALF = DATA_WIDTH / 2;
  localparam logic [HALF-1:0] ONE = HALF'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FILL = 2'd1,
    READ      = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic                      vld_q, vld_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      seeded_q, seeded_d;
  logic [HALF-1:0]           exp_q, exp_d;
  logic                      err_q, err_d;
  logic [ERR_CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic [WORD_CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [DATA_WIDTH-1:0]     first_err_q, first_err_d;

  logic [HALF-1:0] lo, hi;
  logic            bad;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (!rst_busy_i) state_d = WAIT_FILL;
      WAIT_FILL: if (prog_full_i) state_d = READ;
      READ:      state_d = READ;
      default:   state_d = IDLE;
    endcase
    if (rst_busy_i) state_d = IDLE;
  end

  always_comb begin
    vld_d  = rd_valid_i;
    data_d = rd_valid_i ? rdata_i : data_q;
  end

  assign lo = data_q[HALF-1:0];
  assign hi = data_q[DATA_WIDTH-1:HALF];

  // The seed word can only be checked for internal consistency
  always_comb begin
    if (seeded_q) bad = (lo != exp_q) || (hi != exp_q + ONE);
    else          bad = (hi != lo + ONE);
  end

  always_comb begin
    seeded_d    = seeded_q;
    exp_d       = exp_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    word_cnt_d  = word_cnt_q;
    first_err_d = first_err_q;
    if (vld_q) begin
      seeded_d   = 1'b1;
      exp_d      = hi + ONE;
      word_cnt_d = word_cnt_q + WORD_CNT_WIDTH'(1);
      if (bad) begin
        err_d = 1'b1;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
        if (!err_q) first_err_d = data_q;
      end
    end
  end

  always_ff @(posedge rd_clk) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      vld_q       <= 1'b0;
      data_q      <= '0;
      seeded_q    <= 1'b0;
      exp_q       <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      word_cnt_q  <= '0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      vld_q       <= vld_d;
      data_q      <= data_d;
      seeded_q    <= seeded_d;
      exp_q       <= exp_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      word_cnt_q  <= word_cnt_d;
      first_err_q <= first_err_d;
    end
  end

  assign rd_en_o          = (state_q == READ) & enable_i & ~empty_i;
  assign seeded_o         = seeded_q;
  assign err_o            = err_q;
  assign err_cnt_o        = err_cnt_q;
  assign word_cnt_o       = word_cnt_q;
  assign first_err_data_o = first_err_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_fifo_rd_stream_checker.sv
// Scoreboard bench for fifo_rd_stream_checker.
// A second instance with a 2-bit error counter covers saturation.
module tb_fifo_rd_stream_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        rst_busy = 1'b1;
  logic        prog_full = 1'b0;
  logic        empty = 1'b0;
  logic [31:0] rdata = '0;
  logic        rd_valid = 1'b0;

  logic        rd_en, seeded, err;
  logic [15:0] err_cnt;
  logic [31:0] word_cnt, first_err;
  logic [1:0]  state;

  logic        s_rd_en, s_seeded, s_err;
  logic [1:0]  s_err_cnt;
  logic [31:0] s_word_cnt, s_first_err;
  logic [1:0]  s_state;

  always #5 clk = ~clk;

  fifo_rd_stream_checker dut (
    .rd_clk(clk), .sys_rst_n(rst_n), .enable_i(enable),
    .rst_busy_i(rst_busy), .prog_full_i(prog_full),
    .empty_i(empty), .rdata_i(rdata), .rd_valid_i(rd_valid),
    .rd_en_o(rd_en), .seeded_o(seeded), .err_o(err),
    .err_cnt_o(err_cnt), .word_cnt_o(word_cnt),
    .first_err_data_o(first_err), .state_o(state)
  );

  fifo_rd_stream_checker #(.ERR_CNT_WIDTH(2)) dut_sat (
    .rd_clk(clk), .sys_rst_n(rst_n), .enable_i(enable),
    .rst_busy_i(rst_busy), .prog_full_i(prog_full),
    .empty_i(empty), .rdata_i(rdata), .rd_valid_i(rd_valid),
    .rd_en_o(s_rd_en), .seeded_o(s_seeded), .err_o(s_err),
    .err_cnt_o(s_err_cnt), .word_cnt_o(s_word_cnt),
    .first_err_data_o(s_first_err), .state_o(s_state)
  );

  typedef struct {
    logic [31:0] wc;
    logic [15:0] ec;
    logic [1:0]  ecs;
    logic        err;
    logic        seeded;
    logic [31:0] fe;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passes = 0;

  logic [31:0] m_wc;
  logic [15:0] m_ec;
  logic [1:0]  m_ecs;
  logic        m_err, m_seeded;
  logic [31:0] m_fe;

  logic v1 = 1'b0, v2 = 1'b0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h want %0h", name, act, req);
  endtask

  // Output latency tracker: a word valid at edge N is visible after N+1
  always @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= rd_valid;
      v2 <= v1;
    end
  end

  always @(negedge clk) begin
    if (v2) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL sb_underflow: got output with no expectation");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_word_cnt", 64'(word_cnt), 64'(e.wc));
        chk("sb_err_cnt", 64'(err_cnt), 64'(e.ec));
        chk("sb_err_cnt_sat", 64'(s_err_cnt), 64'(e.ecs));
        chk("sb_err", 64'(err), 64'(e.err));
        chk("sb_seeded", 64'(seeded), 64'(e.seeded));
        chk("sb_first_err", 64'(first_err), 64'(e.fe));
      end
    end
  end

  task automatic model_clear();
    m_wc = '0; m_ec = '0; m_ecs = '0;
    m_err = 1'b0; m_seeded = 1'b0; m_fe = '0;
  endtask

  task automatic send(input logic [31:0] d, input logic bad);
    exp_t e;
    @(posedge clk); #1;
    rd_valid = 1'b1;
    rdata = d;
    m_wc = m_wc + 1;
    m_seeded = 1'b1;
    if (bad) begin
      if (!m_err) m_fe = d;
      m_err = 1'b1;
      if (m_ec != 16'hFFFF) m_ec = m_ec + 1;
      if (m_ecs != 2'd3) m_ecs = m_ecs + 1;
    end
    e.wc = m_wc; e.ec = m_ec; e.ecs = m_ecs;
    e.err = m_err; e.seeded = m_seeded; e.fe = m_fe;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rd_valid = 1'b0;
    end
  endtask

  task automatic reset_start();
    @(posedge clk); #1;
    rst_n = 1'b0;
    rd_valid = 1'b0;
    rst_busy = 1'b1;
    prog_full = 1'b0;
    empty = 1'b0;
    enable = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    q.delete();
    model_clear();
    chk("rst_rd_en", 64'(rd_en), 64'(0));
    chk("rst_seeded", 64'(seeded), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_err_cnt", 64'(err_cnt), 64'(0));
    chk("rst_err_cnt_sat", 64'(s_err_cnt), 64'(0));
    chk("rst_word_cnt", 64'(word_cnt), 64'(0));
    chk("rst_first_err", 64'(first_err), 64'(0));
    chk("rst_state", 64'(state), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("busy_idle", 64'(state), 64'(0));
    rst_busy = 1'b0;
    @(posedge clk); #1;
    chk("wait_fill", 64'(state), 64'(1));
    chk("wait_rd_en", 64'(rd_en), 64'(0));
    prog_full = 1'b1;
    @(posedge clk); #1;
    prog_full = 1'b0;
    chk("read_state", 64'(state), 64'(2));
    chk("read_rd_en", 64'(rd_en), 64'(1));
  endtask

  initial begin
    model_clear();
    reset_start();

    for (int i = 0; i < 1000; i++)
      send({16'(2 * i + 1), 16'(2 * i)}, 1'b0);
    idle(3);
    chk("clean_word_cnt", 64'(word_cnt), 64'(1000));
    chk("clean_err", 64'(err), 64'(0));
    chk("clean_seeded", 64'(seeded), 64'(1));

    reset_start();
    send(32'hFFFD_FFFC, 1'b0);
    send(32'hFFFF_FFFE, 1'b0);
    send(32'h0001_0000, 1'b0);
    idle(3);
    chk("wrap_err", 64'(err), 64'(0));

    reset_start();
    send(32'h0000_FFFF, 1'b0);
    send(32'h0002_0001, 1'b0);
    idle(3);
    chk("inword_wrap_err", 64'(err), 64'(0));

    reset_start();
    send(32'h0001_0000, 1'b0);
    send(32'h0003_0002, 1'b0);
    send(32'h0005_0004, 1'b0);
    send(32'h0007_0005, 1'b1);
    send(32'h0009_0008, 1'b0);
    send(32'h000B_000A, 1'b0);
    send(32'h000D_000C, 1'b0);
    empty = 1'b1;
    #1;
    chk("gate_empty", 64'(rd_en), 64'(0));
    send(32'h000F_000E, 1'b0);
    empty = 1'b0;
    enable = 1'b0;
    #1;
    chk("gate_enable", 64'(rd_en), 64'(0));
    enable = 1'b1;
    #1;
    chk("gate_release", 64'(rd_en), 64'(1));
    idle(3);
    chk("corr_err_cnt", 64'(err_cnt), 64'(1));
    chk("corr_err", 64'(err), 64'(1));
    chk("corr_first_err", 64'(first_err), 64'h0007_0005);
    chk("corr_word_cnt", 64'(word_cnt), 64'(8));

    repeat (6) send(32'hDEAD_BEEF, 1'b1);
    idle(3);
    chk("sat_err_cnt", 64'(s_err_cnt), 64'(3));
    chk("nosat_err_cnt", 64'(err_cnt), 64'(7));
    chk("sat_first_err", 64'(first_err), 64'h0007_0005);

    send(32'h0002_0001, 1'b1);
    send(32'h0004_0003, 1'b0);
    reset_start();
    send(32'h1235_1234, 1'b0);
    send(32'h1237_1236, 1'b0);
    idle(3);
    chk("reseed_err", 64'(err), 64'(0));
    chk("reseed_word_cnt", 64'(word_cnt), 64'(2));

    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL sb_leftover: got %0d pending want 0", q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
